// File: rtl/serial_tx_framed.sv
// Framed serial transmitter: a DEPTH-word input FIFO feeding a start/data/parity/stop
// serialiser. Queued words leave back-to-back with no idle gap between frames.
module serial_tx_framed #(
    parameter int DATA_W     = 55,
    parameter int DEPTH      = 4,
    parameter int BIT_CYCLES = 1,
    parameter int PARITY_EN  = 0,
    parameter int STOP_BITS  = 1,
    parameter int MSB_FIRST  = 0,
    parameter int IDLE_LVL   = 0
) (
    input  logic                       Clk_S,
    input  logic                       Rst,
    input  logic [DATA_W-1:0]          TX_Data,
    input  logic                       TX_Data_Valid,
    output logic                       TX_Ready,
    output logic                       S_Data,
    output logic                       TX_Busy,
    output logic [$clog2(DEPTH+1)-1:0] Fifo_Count
);

    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STOP_CYC = STOP_BITS * BIT_CYCLES;
    localparam int CYC_W    = $clog2(STOP_CYC + 1);
    localparam int BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic             IDLE_BIT  = (IDLE_LVL != 0);
    localparam logic [CYC_W-1:0] BIT_LAST  = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] STOP_LAST = CYC_W'(STOP_CYC - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Handshake: a word transfers on a rising edge where TX_Data_Valid and TX_Ready
    // are both high; TX_Ready is registered and never depends on a same-edge pop.

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nx;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [DATA_W-1:0] head;

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [CYC_W-1:0]  cyc;
    logic [CYC_W-1:0]  cyc_nx;
    logic [BIT_W-1:0]  bit_idx;
    logic [BIT_W-1:0]  bit_nx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nx;
    logic [DATA_W-1:0] shifted;
    logic              out_bit;
    logic              parity_bit;
    logic              par_nx;
    logic              s_data_nx;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty = (count == '0);
    assign head       = mem[rd_ptr];
    assign push       = TX_Data_Valid && TX_Ready && !Rst;
    assign Fifo_Count = count;
    assign TX_Busy    = (state != ST_IDLE);

    // The bit on the line is always the end of the shift register nearest the output.
    assign out_bit = (MSB_FIRST != 0) ? shreg[DATA_W-1] : shreg[0];
    assign shifted = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);

    always_comb begin
        state_nx  = state;
        cyc_nx    = cyc + 1'b1;
        bit_nx    = bit_idx;
        shreg_nx  = shreg;
        par_nx    = parity_bit;
        s_data_nx = S_Data;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                cyc_nx    = '0;
                s_data_nx = IDLE_BIT;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shreg_nx  = head;
                    par_nx    = ^head;
                    state_nx  = ST_START;
                    s_data_nx = ~IDLE_BIT;
                end
            end
            ST_START: begin
                if (cyc == BIT_LAST) begin
                    cyc_nx    = '0;
                    bit_nx    = '0;
                    state_nx  = ST_DATA;
                    s_data_nx = out_bit;
                    shreg_nx  = shifted;
                end
            end
            ST_DATA: begin
                if (cyc == BIT_LAST) begin
                    cyc_nx = '0;
                    if (bit_idx == DATA_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_nx  = ST_PARITY;
                            s_data_nx = parity_bit;
                        end else begin
                            state_nx  = ST_STOP;
                            s_data_nx = IDLE_BIT;
                        end
                    end else begin
                        bit_nx    = bit_idx + 1'b1;
                        s_data_nx = out_bit;
                        shreg_nx  = shifted;
                    end
                end
            end
            ST_PARITY: begin
                if (cyc == BIT_LAST) begin
                    cyc_nx    = '0;
                    state_nx  = ST_STOP;
                    s_data_nx = IDLE_BIT;
                end
            end
            ST_STOP: begin
                if (cyc == STOP_LAST) begin
                    cyc_nx = '0;
                    // Chain straight into the next start bit when a word is waiting.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shreg_nx  = head;
                        par_nx    = ^head;
                        state_nx  = ST_START;
                        s_data_nx = ~IDLE_BIT;
                    end else begin
                        state_nx  = ST_IDLE;
                        s_data_nx = IDLE_BIT;
                    end
                end
            end
            default: begin
                cyc_nx    = '0;
                state_nx  = ST_IDLE;
                s_data_nx = IDLE_BIT;
            end
        endcase
    end

    always_comb begin
        count_nx = count;
        case ({push, pop})
            2'b10:   count_nx = count + 1'b1;
            2'b01:   count_nx = count - 1'b1;
            default: count_nx = count;
        endcase
    end

    always_ff @(posedge Clk_S) begin
        if (push) begin
            mem[wr_ptr] <= TX_Data;
        end
    end

    always_ff @(posedge Clk_S) begin
        if (Rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            TX_Ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count    <= count_nx;
            TX_Ready <= (count_nx < DEPTH_C);
        end
    end

    always_ff @(posedge Clk_S) begin
        if (Rst) begin
            state      <= ST_IDLE;
            cyc        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            S_Data     <= IDLE_BIT;
        end else begin
            state      <= state_nx;
            cyc        <= cyc_nx;
            bit_idx    <= bit_nx;
            shreg      <= shreg_nx;
            parity_bit <= par_nx;
            S_Data     <= s_data_nx;
        end
    end

endmodule

// File: tb/tb_serial_tx_framed.sv
// Bench for serial_tx_framed: three configurations checked cycle by cycle against a
// line-level model that expands each accepted word into its expected frame samples.
module tb_serial_tx_framed;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [54:0] tx_data0;
    logic        tx_valid0, tx_ready0, s_data0, tx_busy0;
    logic [2:0]  fifo_count0;
    logic [7:0]  tx_data1;
    logic        tx_valid1, tx_ready1, s_data1, tx_busy1;
    logic [2:0]  fifo_count1;
    logic [7:0]  tx_data2;
    logic        tx_valid2, tx_ready2, s_data2, tx_busy2;
    logic [1:0]  fifo_count2;

    serial_tx_framed dut0 (
        .Clk_S(clk), .Rst(rst), .TX_Data(tx_data0), .TX_Data_Valid(tx_valid0),
        .TX_Ready(tx_ready0), .S_Data(s_data0), .TX_Busy(tx_busy0), .Fifo_Count(fifo_count0)
    );

    serial_tx_framed #(
        .DATA_W(8), .DEPTH(4), .BIT_CYCLES(4), .PARITY_EN(1), .STOP_BITS(2), .MSB_FIRST(0)
    ) dut1 (
        .Clk_S(clk), .Rst(rst), .TX_Data(tx_data1), .TX_Data_Valid(tx_valid1),
        .TX_Ready(tx_ready1), .S_Data(s_data1), .TX_Busy(tx_busy1), .Fifo_Count(fifo_count1)
    );

    serial_tx_framed #(
        .DATA_W(8), .DEPTH(3), .BIT_CYCLES(4), .PARITY_EN(1), .STOP_BITS(2), .MSB_FIRST(1)
    ) dut2 (
        .Clk_S(clk), .Rst(rst), .TX_Data(tx_data2), .TX_Data_Valid(tx_valid2),
        .TX_Ready(tx_ready2), .S_Data(s_data2), .TX_Busy(tx_busy2), .Fifo_Count(fifo_count2)
    );

    int cfg_dw[3], cfg_bc[3], cfg_par[3], cfg_sb[3], cfg_msb[3], cfg_depth[3];

    // Scoreboard: one entry per future line sample, {first_start_cycle, busy, line}.
    logic [2:0] exp_q[$];
    int         pending;
    logic       ready_m;
    int         sel;
    int         n_assert;
    int         n_fail;

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s (dut%0d): observed %0h expected %0h", tag, sel, obs, exp);
        end
    endtask

    task automatic build_frame(input logic [63:0] w);
        int dw, bc, sb, idx;
        logic [63:0] m;
        logic par;
        dw = cfg_dw[sel];
        bc = cfg_bc[sel];
        sb = cfg_sb[sel];
        m = w & ((64'd1 << dw) - 64'd1);
        par = ^m;
        for (int c = 0; c < bc; c++) exp_q.push_back({(c == 0), 1'b1, 1'b1});
        for (int i = 0; i < dw; i++) begin
            idx = (cfg_msb[sel] != 0) ? (dw - 1 - i) : i;
            for (int c = 0; c < bc; c++) exp_q.push_back({1'b0, 1'b1, m[idx]});
        end
        if (cfg_par[sel] != 0)
            for (int c = 0; c < bc; c++) exp_q.push_back({1'b0, 1'b1, par});
        for (int c = 0; c < sb * bc; c++) exp_q.push_back({1'b0, 1'b1, 1'b0});
    endtask

    // Drive one clock of stimulus for the selected DUT, advance the model, compare.
    task automatic step(input logic v, input logic [63:0] d, input logic r, output logic acc);
        logic [2:0]  e;
        logic [63:0] line, busy, rdy, cnt;
        rst = r;
        tx_valid0 = v && (sel == 0);
        tx_valid1 = v && (sel == 1);
        tx_valid2 = v && (sel == 2);
        tx_data0 = d[54:0];
        tx_data1 = d[7:0];
        tx_data2 = d[7:0];
        acc = !r && v && ready_m;
        if (acc) begin
            if (exp_q.size() == 0) exp_q.push_back(3'b000);
            build_frame(d);
        end
        @(posedge clk);
        @(negedge clk);
        if (r) begin
            exp_q.delete();
            pending = 0;
            ready_m = 1'b0;
            e = 3'b000;
        end else begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'b000;
            if (acc) pending++;
            if (e[2]) pending--;
            ready_m = (pending < cfg_depth[sel]);
        end
        case (sel)
            0: begin line = 64'(s_data0); busy = 64'(tx_busy0); rdy = 64'(tx_ready0); cnt = 64'(fifo_count0); end
            1: begin line = 64'(s_data1); busy = 64'(tx_busy1); rdy = 64'(tx_ready1); cnt = 64'(fifo_count1); end
            default: begin line = 64'(s_data2); busy = 64'(tx_busy2); rdy = 64'(tx_ready2); cnt = 64'(fifo_count2); end
        endcase
        check("s_data", line, 64'(e[0]));
        check("tx_busy", busy, 64'(e[1]));
        check("tx_ready", rdy, 64'(ready_m));
        check("fifo_count", cnt, 64'(pending));
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && pending == 0) break;
            step(1'b0, rand64(), 1'b0, a);
        end
        step(1'b0, rand64(), 1'b0, a);
    endtask

    task automatic random_phase(input int cycles, input int rate);
        logic a;
        for (int i = 0; i < cycles; i++) begin
            step(($urandom_range(0, rate - 1) == 0), rand64(), 1'b0, a);
        end
        drain();
    endtask

    task automatic reset_and_release(input int hold);
        logic a;
        for (int i = 0; i < hold; i++) step(1'b1, rand64(), 1'b1, a);
        step(1'b0, rand64(), 1'b0, a);
    endtask

    initial begin
        logic a;
        int   n_acc;
        logic [63:0] w;
        cfg_dw    = '{55, 8, 8};
        cfg_bc    = '{1, 4, 4};
        cfg_par   = '{0, 1, 1};
        cfg_sb    = '{1, 2, 2};
        cfg_msb   = '{0, 0, 1};
        cfg_depth = '{4, 4, 3};
        n_assert = 0;
        n_fail = 0;
        pending = 0;
        ready_m = 1'b0;
        sel = 0;
        rst = 1'b1;
        tx_valid0 = 1'b0; tx_valid1 = 1'b0; tx_valid2 = 1'b0;
        tx_data0 = '0; tx_data1 = '0; tx_data2 = '0;

        // Reset held 5 cycles with valid high: nothing accepted, ready rises after release.
        reset_and_release(5);

        // Single word 3: start, 1, 1, 53 zeros, stop.
        step(1'b1, 64'd3, 1'b0, a);
        drain();

        // Valid held with distinct words: five accepted, frames contiguous and in order.
        for (int i = 0; i < 10; i++) step(1'b1, 64'(i + 100), 1'b0, a);
        drain();

        random_phase(400, 25);

        // Reset in the middle of the first of three queued frames.
        for (int i = 0; i < 3; i++) step(1'b1, rand64(), 1'b0, a);
        for (int i = 0; i < 18; i++) step(1'b0, rand64(), 1'b0, a);
        step(1'b0, rand64(), 1'b1, a);
        for (int i = 0; i < 70; i++) step(1'b0, rand64(), 1'b0, a);

        // Parity, two stop bits, 4 cycles per bit, LSB first.
        sel = 1;
        reset_and_release(1);
        step(1'b1, 64'hB5, 1'b0, a);
        drain();
        for (int i = 0; i < 6; i++) step(1'b1, rand64(), 1'b0, a);
        drain();
        random_phase(300, 12);

        // Same framing MSB first, three-deep FIFO so pointers wrap at a non power of two.
        sel = 2;
        reset_and_release(1);
        step(1'b1, 64'hB5, 1'b0, a);
        drain();
        n_acc = 0;
        w = 64'd1;
        for (int i = 0; i < 2000 && n_acc < 10; i++) begin
            step(1'b1, w, 1'b0, a);
            if (a) begin
                n_acc++;
                w = w + 64'd17;
            end
        end
        drain();
        random_phase(300, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_tx_framed.md
Name: serial_tx_framed

Overview:
Parametrised successor to the single-word serial transmitter. Accepts parallel words of DATA_W bits through a valid/ready handshake into a DEPTH-entry FIFO and serialises each word onto S_Data as a framed packet: start bit, data, optional even parity, then STOP_BITS stop bits. Each bit is held for BIT_CYCLES clocks. Queued words are sent back-to-back with no idle gap. Sits on the router TX side and drives the serial link to the matching receiver.

Parameters:
DATA_W, 55, payload width in bits (>=1)
DEPTH, 4, input FIFO depth in words (>=1)
BIT_CYCLES, 1, clocks per serial bit (>=1)
PARITY_EN, 0, 1 = append even-parity bit after data
STOP_BITS, 1, number of stop bits (1..4)
MSB_FIRST, 0, 0 = data LSB first, 1 = data MSB first
IDLE_LVL, 0, line level when idle and for stop bits; start bit = ~IDLE_LVL

Ports:
Clk_S  input  1  single clock; all logic on rising edge
Rst  input  1  synchronous active-high reset
TX_Data  input  DATA_W  word to transmit
TX_Data_Valid  input  1  TX_Data is valid
TX_Ready  output  1  FIFO can accept a word this cycle
S_Data  output  1  registered serial line
TX_Busy  output  1  a frame is on the line (any state other than IDLE)
Fifo_Count  output  $clog2(DEPTH+1)  words queued, excluding the frame in flight

Behaviour:
- Reset: the only clock is Clk_S. Rst is synchronous and active-high. While Rst=1 at an edge: S_Data=IDLE_LVL, TX_Ready=0, TX_Busy=0, Fifo_Count=0, FIFO flushed, FSM=IDLE, bit/cycle counters=0. Reset takes priority over every other event, including mid-frame; the frame in flight is abandoned with no stop bits. TX_Ready is a register and rises on the first edge with Rst=0.
- Handshake: a word is accepted at an edge where TX_Data_Valid=1 and TX_Ready=1. Otherwise TX_Data is ignored, with no error. TX_Ready = (count < DEPTH), registered. There is no full-bypass: when full, a push is refused even if a pop happens on the same edge. A simultaneous push and pop when not full leaves the count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: S_Data=IDLE_LVL. If the FIFO is non-empty, pop the head into the shift register, compute parity = XOR of all data bits, and go to START.
- Latency: a word accepted at edge k into an empty FIFO with FSM idle is popped at edge k+1. S_Data shows the start bit from edge k+1.
- START: S_Data=~IDLE_LVL for BIT_CYCLES clocks, then DATA.
- DATA: DATA_W bits, each held BIT_CYCLES clocks, in the order set by MSB_FIRST. Then PARITY if PARITY_EN, else STOP.
- PARITY: S_Data=parity for BIT_CYCLES clocks (even parity: ones in data plus parity bit is even).
- STOP: S_Data=IDLE_LVL for STOP_BITS*BIT_CYCLES clocks. On the last stop cycle: if the FIFO is non-empty, pop and go directly to START (the next start bit follows with no gap); else go to IDLE.
- Frame length: F = BIT_CYCLES*(1+DATA_W+PARITY_EN+STOP_BITS) clocks.
- TX_Busy=1 in every state except IDLE.
- Fifo_Count always reflects the registered occupancy.
- The FIFO is circular. Read and write pointers wrap at DEPTH, including when DEPTH is not a power of 2.
- A pop occurs only at IDLE exit or at the end of STOP, never mid-frame. TX_Data changes after acceptance do not affect a queued or in-flight word.

Test Plan:
1. Defaults; hold Rst=1 for 5 cycles with TX_Data_Valid=1 -> TX_Ready=0, S_Data=0, TX_Busy=0, Fifo_Count=0 throughout, nothing accepted. TX_Ready=1 at the first edge after Rst=0.
2. Defaults; push 55'd3 at edge k -> S_Data=1 (start) at k+1, then 1,1 followed by 53 zeros, then stop 0. TX_Busy high for exactly 57 cycles; Fifo_Count returns to 0 at k+1.
3. Defaults; hold TX_Data_Valid=1 with distinct words from an idle, empty state -> exactly 5 words accepted (edges k..k+4). TX_Ready=0 from k+5 and Fifo_Count=4 after k+4. All 5 frames are contiguous (285 busy cycles, no idle gap) and delivered in order.
4. DATA_W=8, PARITY_EN=1, STOP_BITS=2, BIT_CYCLES=4, push 8'hB5 -> start 1, data 1,0,1,0,1,1,0,1 (LSB first), parity 1, stop 0,0. Each bit is 4 cycles wide; 48-cycle frame.
5. Same configuration as 4 with MSB_FIRST=1, push 8'hB5 -> data 1,0,1,1,0,1,0,1, parity 1; wrap test: push and drain 10 words -> all emitted in order.
6. Defaults; 3 words queued, assert Rst at cycle 20 of the first frame for 1 cycle -> S_Data=0, Fifo_Count=0, TX_Busy=0 at the next edge. No further frames after release; TX_Ready=1 one edge after release.
